fp_encoder_seq: RTL

FP_ENCODER_SEQ -- requirements
Module: fp_encoder_seq

---
 rtl/fp_encoder_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/fp_encoder_seq.sv
// fp_encoder_seq: converts a signed or unsigned integer sample into a small
// sign/exponent/significand float by shifting one bit per cycle, then rounding half-up.
module fp_encoder_seq #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [MW-1:0] out_f,
    output logic          out_sat
);
    localparam logic [EW-1:0] EMAX = '1;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t        state;
    logic [DW-1:0] w;
    logic [DW-1:0] mag;
    logic [EW-1:0] e;
    logic          r;
    logic          neg;
    logic          big;
    always_comb begin
        neg = in_signed && in_data[DW-1];
        // the most negative sample has no positive twin, so clamp its magnitude
        mag = !neg ? in_data
            : (in_data == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}}
            : -in_data;
        big = |w[DW-1:MW];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_s     <= 1'b0;
            out_e     <= '0;
            out_f     <= '0;
            out_sat   <= 1'b0;
            w         <= '0;
            e         <= '0;
            r         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        state    <= NORM;
                        in_ready <= 1'b0;
                        w        <= mag;
                        e        <= '0;
                        r        <= 1'b0;
                        out_s    <= neg;
                    end
                end
                NORM: begin
                    if (big && e != EMAX) begin
                        r <= w[0];
                        w <= w >> 1;
                        e <= e + 1'b1;
                    end else if (big) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_e     <= e;
                        out_f     <= '1;
                        out_sat   <= 1'b1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    out_e     <= e;
                    out_f     <= w[MW-1:0];
                    out_sat   <= 1'b0;
                    // round-up of an all-ones significand carries into the exponent
                    if (r && !(&w[MW-1:0])) begin
                        out_f <= w[MW-1:0] + 1'b1;
                    end else if (r && e != EMAX) begin
                        out_f <= {1'b1, {(MW-1){1'b0}}};
                        out_e <= e + 1'b1;
                    end else if (r) begin
                        out_f   <= '1;
                        out_sat <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
